unified_mem_arbiter: RTL

UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

---
 rtl/unified_mem_arbiter_if.sv | 36 +++
 rtl/unified_mem_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the fetch port, data port, memory port and stall signals around the arbiter.
// slave is the arbiter's view; master is the pipeline/memory side.
interface unified_mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic            IReq;
  logic [XLEN-1:0] IAddr;
  logic [XLEN-1:0] IRdata;
  logic            IReady;
  logic            DReq;
  logic            DWe;
  logic [XLEN-1:0] DAddr;
  logic [XLEN-1:0] DWdata;
  logic [XLEN-1:0] DRdata;
  logic            DReady;
  logic            MemReq;
  logic            MemWe;
  logic [XLEN-1:0] MemAddr;
  logic [XLEN-1:0] MemWdata;
  logic            MemAck;
  logic [XLEN-1:0] MemRdata;
  logic            StallF;
  logic            StallM;

  modport slave (
    input  IReq, IAddr, DReq, DWe, DAddr, DWdata, MemAck, MemRdata,
    output IRdata, IReady, DRdata, DReady, MemReq, MemWe, MemAddr, MemWdata,
           StallF, StallM
  );

  modport master (
    output IReq, IAddr, DReq, DWe, DAddr, DWdata, MemAck, MemRdata,
    input  IRdata, IReady, DRdata, DReady, MemReq, MemWe, MemAddr, MemWdata,
           StallF, StallM
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Data wins ties, but fetch is forced through after MAX_D_RUN back-to-back data grants.
module unified_mem_arbiter #(
  parameter int XLEN      = 32,
  parameter int MAX_D_RUN = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  unified_mem_arbiter_if.slave bus
);

  localparam int CW = (MAX_D_RUN < 1) ? 1 : $clog2(MAX_D_RUN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(MAX_D_RUN);

  typedef enum logic [1:0] {IDLE, SERV_D, SERV_I} state_e;

  state_e          state_q;
  logic [CW-1:0]   run_q, run_d;
  logic [XLEN-1:0] addr_q, wdata_q, irdata_q, drdata_q;
  logic            we_q, iready_q, dready_q, mem_req_q, mem_we_q;
  logic            i_elig, d_elig, pick_d, pick_i;

  // A port that is showing Ready this cycle has just been served and is not eligible.
  always_comb begin
    i_elig = bus.IReq & ~iready_q;
    d_elig = bus.DReq & ~dready_q;
    pick_d = d_elig & (~i_elig | (run_q != RUN_MAX));
    pick_i = i_elig & ~pick_d;
    run_d  = run_q;
    if (!bus.IReq || pick_i) begin
      run_d = '0;
    end else if (pick_d && (run_q != RUN_MAX)) begin
      run_d = run_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      run_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      irdata_q  <= '0;
      drdata_q  <= '0;
      iready_q  <= 1'b0;
      dready_q  <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      iready_q <= 1'b0;
      dready_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          run_q <= run_d;
          if (pick_d) begin
            state_q   <= SERV_D;
            addr_q    <= bus.DAddr;
            we_q      <= bus.DWe;
            wdata_q   <= bus.DWdata;
            mem_req_q <= 1'b1;
            mem_we_q  <= bus.DWe;
          end else if (pick_i) begin
            state_q   <= SERV_I;
            addr_q    <= bus.IAddr;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b0;
          end
        end
        SERV_D: begin
          if (bus.MemAck) begin
            state_q   <= IDLE;
            dready_q  <= 1'b1;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (!we_q) begin
              drdata_q <= bus.MemRdata;
            end
          end
        end
        SERV_I: begin
          if (bus.MemAck) begin
            state_q   <= IDLE;
            iready_q  <= 1'b1;
            irdata_q  <= bus.MemRdata;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MemReq   = mem_req_q;
  assign bus.MemWe    = mem_we_q;
  assign bus.MemAddr  = addr_q;
  assign bus.MemWdata = wdata_q;
  assign bus.IRdata   = irdata_q;
  assign bus.IReady   = iready_q;
  assign bus.DRdata   = drdata_q;
  assign bus.DReady   = dready_q;
  assign bus.StallM   = bus.DReq & ~dready_q;
  assign bus.StallF   = (bus.IReq & ~iready_q) | bus.StallM;

endmodule
